// File: rtl/sim_test_sequencer_if.sv
// Signal bundle between the run sequencer and the bench top / test register block.
// master is the sequencer side; slave is the bench side that drives the test words.
interface sim_test_sequencer_if;
    logic [31:0] test_progress;
    logic [31:0] test_pass;
    logic [31:0] test_fail;
    logic        dut_rst;
    logic        progress_evt;
    logic [31:0] progress_value;
    logic [31:0] cycle_count;
    logic        done;
    logic [1:0]  result;
    logic [31:0] result_code;

    modport master (
        input  test_progress,
        input  test_pass,
        input  test_fail,
        output dut_rst,
        output progress_evt,
        output progress_value,
        output cycle_count,
        output done,
        output result,
        output result_code
    );

    modport slave (
        output test_progress,
        output test_pass,
        output test_fail,
        input  dut_rst,
        input  progress_evt,
        input  progress_value,
        input  cycle_count,
        input  done,
        input  result,
        input  result_code
    );
endinterface

// File: rtl/sim_test_sequencer.sv
// Simulation run controller: releases DUT reset, tracks progress, applies clock/stall limits,
// then drains a few cycles before raising a sticky done with a result class and code.
module sim_test_sequencer #(
    parameter logic [31:0] MAX_CLOCKS   = 32'd100000,
    parameter logic [31:0] STALL_CLOCKS = 32'd20000,
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input logic                  sim_clk,
    input logic                  sim_rst,
    sim_test_sequencer_if.master ctl_io
);

    localparam logic [31:0] HoldLast  = 32'(RST_CYCLES - 1);
    localparam logic [31:0] DrainLast = 32'(DRAIN_CYCLES - 1);
    localparam logic [31:0] MaxLast   = MAX_CLOCKS - 32'd1;
    localparam logic [31:0] StallLast = STALL_CLOCKS - 32'd1;

    localparam logic [1:0] ResNone    = 2'b00;
    localparam logic [1:0] ResPass    = 2'b01;
    localparam logic [1:0] ResFail    = 2'b10;
    localparam logic [1:0] ResTimeout = 2'b11;

    localparam logic [31:0] CodeClockLimit = 32'h0000_0001;
    localparam logic [31:0] CodeStall      = 32'h0000_0002;

    typedef enum logic [1:0] {
        StHold,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] drain_cnt_q, drain_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] progress_value_q, progress_value_d;
    logic [31:0] result_code_q, result_code_d;
    logic [1:0]  result_q, result_d;
    logic        dut_rst_q, dut_rst_d;
    logic        progress_evt_q, progress_evt_d;
    logic        done_q, done_d;

    logic        prog_change;
    logic        term;
    logic [1:0]  term_result;
    logic [31:0] term_code;

    always_ff @(posedge sim_clk or posedge sim_rst) begin
        if (sim_rst) begin
            state_q          <= StHold;
            hold_cnt_q       <= '0;
            drain_cnt_q      <= '0;
            stall_cnt_q      <= '0;
            cycle_count_q    <= '0;
            progress_value_q <= '0;
            result_code_q    <= '0;
            result_q         <= ResNone;
            dut_rst_q        <= 1'b1;
            progress_evt_q   <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            hold_cnt_q       <= hold_cnt_d;
            drain_cnt_q      <= drain_cnt_d;
            stall_cnt_q      <= stall_cnt_d;
            cycle_count_q    <= cycle_count_d;
            progress_value_q <= progress_value_d;
            result_code_q    <= result_code_d;
            result_q         <= result_d;
            dut_rst_q        <= dut_rst_d;
            progress_evt_q   <= progress_evt_d;
            done_q           <= done_d;
        end
    end

    assign prog_change = (ctl_io.test_progress != progress_value_q);

    // Terminal priority: fail, pass, clock limit, stall.
    always_comb begin
        term        = 1'b1;
        term_result = ResNone;
        term_code   = '0;
        if (ctl_io.test_fail != 32'd0) begin
            term_result = ResFail;
            term_code   = ctl_io.test_fail;
        end else if (ctl_io.test_pass != 32'd0) begin
            term_result = ResPass;
            term_code   = ctl_io.test_pass;
        end else if (cycle_count_q == MaxLast) begin
            term_result = ResTimeout;
            term_code   = CodeClockLimit;
        end else if ((STALL_CLOCKS != 32'd0) && (stall_cnt_q == StallLast) && !prog_change) begin
            term_result = ResTimeout;
            term_code   = CodeStall;
        end else begin
            term = 1'b0;
        end
    end

    always_comb begin
        state_d          = state_q;
        hold_cnt_d       = hold_cnt_q;
        drain_cnt_d      = drain_cnt_q;
        stall_cnt_d      = stall_cnt_q;
        cycle_count_d    = cycle_count_q;
        progress_value_d = progress_value_q;
        result_code_d    = result_code_q;
        result_d         = result_q;
        dut_rst_d        = dut_rst_q;
        progress_evt_d   = 1'b0;
        done_d           = done_q;

        unique case (state_q)
            StHold: begin
                hold_cnt_d = hold_cnt_q + 32'd1;
                if (hold_cnt_q == HoldLast) begin
                    // Baseline progress is captured silently so the first word is not an event.
                    dut_rst_d        = 1'b0;
                    progress_value_d = ctl_io.test_progress;
                    state_d          = StRun;
                end
            end
            StRun: begin
                cycle_count_d = cycle_count_q + 32'd1;
                if (prog_change) begin
                    progress_value_d = ctl_io.test_progress;
                    progress_evt_d   = 1'b1;
                    stall_cnt_d      = '0;
                end else if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + 32'd1;
                end
                if (term) begin
                    result_d      = term_result;
                    result_code_d = term_code;
                    drain_cnt_d   = '0;
                    state_d       = StDrain;
                end
            end
            StDrain: begin
                if (prog_change) begin
                    progress_value_d = ctl_io.test_progress;
                    progress_evt_d   = 1'b1;
                end
                if (drain_cnt_q == DrainLast) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    drain_cnt_d = drain_cnt_q + 32'd1;
                end
            end
            StDone: begin
            end
            default: begin
                state_d = StHold;
            end
        endcase
    end

    assign ctl_io.dut_rst        = dut_rst_q;
    assign ctl_io.progress_evt   = progress_evt_q;
    assign ctl_io.progress_value = progress_value_q;
    assign ctl_io.cycle_count    = cycle_count_q;
    assign ctl_io.done           = done_q;
    assign ctl_io.result         = result_q;
    assign ctl_io.result_code    = result_code_q;

endmodule

// File: tb/tb_sim_test_sequencer.sv
// Directed bench for sim_test_sequencer: one instance exercises progress/pass/fail/stall,
// a second with a short clock limit and no stall watchdog checks the global timeout.
module tb_sim_test_sequencer;

    logic sim_clk;
    logic sim_rst;
    int   n_checks;
    int   n_errors;

    sim_test_sequencer_if ib ();
    sim_test_sequencer_if it ();

    sim_test_sequencer #(
        .MAX_CLOCKS  (32'd1000),
        .STALL_CLOCKS(32'd20),
        .RST_CYCLES  (4),
        .DRAIN_CYCLES(2)
    ) dut_m (
        .sim_clk(sim_clk),
        .sim_rst(sim_rst),
        .ctl_io (ib.master)
    );

    sim_test_sequencer #(
        .MAX_CLOCKS  (32'd50),
        .STALL_CLOCKS(32'd0),
        .RST_CYCLES  (4),
        .DRAIN_CYCLES(2)
    ) dut_t (
        .sim_clk(sim_clk),
        .sim_rst(sim_rst),
        .ctl_io (it.master)
    );

    initial begin
        sim_clk = 1'b0;
        forever #5 sim_clk = ~sim_clk;
    end

    task automatic tick();
        @(posedge sim_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dut_rst"}, 32'(ib.dut_rst), 32'd1);
        chk({tag, "_evt"}, 32'(ib.progress_evt), 32'd0);
        chk({tag, "_pv"}, ib.progress_value, 32'd0);
        chk({tag, "_cc"}, ib.cycle_count, 32'd0);
        chk({tag, "_done"}, 32'(ib.done), 32'd0);
        chk({tag, "_result"}, 32'(ib.result), 32'd0);
        chk({tag, "_code"}, ib.result_code, 32'd0);
        chk({tag, "_t_dut_rst"}, 32'(it.dut_rst), 32'd1);
        chk({tag, "_t_done"}, 32'(it.done), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        sim_rst  = 1'b0;
        ib.test_progress = '0;
        ib.test_pass     = '0;
        ib.test_fail     = '0;
        it.test_progress = '0;
        it.test_pass     = '0;
        it.test_fail     = '0;

        // Reset and release: dut_rst high across exactly 4 edges after the fall.
        #1 sim_rst = 1'b1;
        #1 chk_reset_vals("rst_async");
        repeat (3) tick();
        chk_reset_vals("rst_held");
        sim_rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("hold_dut_rst", 32'(ib.dut_rst), 32'd1);
        end
        tick();
        chk("run_dut_rst", 32'(ib.dut_rst), 32'd0);
        chk("run_t_dut_rst", 32'(it.dut_rst), 32'd0);
        chk("run_cc0", ib.cycle_count, 32'd0);
        chk("run_evt0", 32'(ib.progress_evt), 32'd0);

        // Progress 0 -> 5 -> 5 -> 7.
        tick();
        chk("prog0_evt", 32'(ib.progress_evt), 32'd0);
        chk("prog0_cc", ib.cycle_count, 32'd1);
        ib.test_progress = 32'd5;
        tick();
        chk("prog5_evt", 32'(ib.progress_evt), 32'd1);
        chk("prog5_pv", ib.progress_value, 32'd5);
        tick();
        chk("prog5b_evt", 32'(ib.progress_evt), 32'd0);
        chk("prog5b_pv", ib.progress_value, 32'd5);
        ib.test_progress = 32'd7;
        tick();
        chk("prog7_evt", 32'(ib.progress_evt), 32'd1);
        chk("prog7_pv", ib.progress_value, 32'd7);
        chk("prog7_cc", ib.cycle_count, 32'd4);
        repeat (6) tick();
        chk("idle_evt", 32'(ib.progress_evt), 32'd0);
        chk("idle_pv", ib.progress_value, 32'd7);
        chk("idle_cc", ib.cycle_count, 32'd10);
        chk("idle_result", 32'(ib.result), 32'd0);

        // Pass sampled at RUN cycle 10.
        ib.test_pass = 32'h0000_00AA;
        tick();
        chk("pass_result", 32'(ib.result), 32'd1);
        chk("pass_code", ib.result_code, 32'h0000_00AA);
        chk("pass_cc", ib.cycle_count, 32'd11);
        chk("pass_done0", 32'(ib.done), 32'd0);
        ib.test_pass     = '0;
        ib.test_fail     = 32'h0000_FFFF;
        ib.test_progress = 32'd9;
        tick();
        chk("drain_evt", 32'(ib.progress_evt), 32'd1);
        chk("drain_pv", ib.progress_value, 32'd9);
        chk("drain_done0", 32'(ib.done), 32'd0);
        chk("drain_result", 32'(ib.result), 32'd1);
        chk("drain_cc", ib.cycle_count, 32'd11);
        tick();
        chk("pass_done", 32'(ib.done), 32'd1);
        chk("pass_done_result", 32'(ib.result), 32'd1);
        chk("pass_done_code", ib.result_code, 32'h0000_00AA);
        chk("pass_done_cc", ib.cycle_count, 32'd11);
        chk("pass_done_evt", 32'(ib.progress_evt), 32'd0);
        ib.test_progress = 32'd11;
        tick();
        chk("done_evt", 32'(ib.progress_evt), 32'd0);
        chk("done_pv", ib.progress_value, 32'd9);
        chk("done_hold", 32'(ib.done), 32'd1);
        ib.test_fail = '0;

        // Clock limit on the short instance: terminal on the 50th RUN edge.
        repeat (35) tick();
        chk("max_pre_cc", it.cycle_count, 32'd49);
        chk("max_pre_result", 32'(it.result), 32'd0);
        tick();
        chk("max_result", 32'(it.result), 32'd3);
        chk("max_code", it.result_code, 32'h0000_0001);
        chk("max_cc", it.cycle_count, 32'd50);
        chk("max_done0", 32'(it.done), 32'd0);
        tick();
        chk("max_done1", 32'(it.done), 32'd0);
        tick();
        chk("max_done", 32'(it.done), 32'd1);
        chk("max_done_cc", it.cycle_count, 32'd50);

        // Async reset while in DONE.
        sim_rst = 1'b1;
        #1;
        chk("rst_done_done", 32'(ib.done), 32'd0);
        chk("rst_done_result", 32'(ib.result), 32'd0);
        chk("rst_done_dut_rst", 32'(ib.dut_rst), 32'd1);
        chk("rst_done_pv", ib.progress_value, 32'd0);
        repeat (2) tick();
        ib.test_progress = '0;
        sim_rst = 1'b0;
        repeat (3) tick();
        tick();
        chk("run2_dut_rst", 32'(ib.dut_rst), 32'd0);

        // Fail and pass together; progress change in the same cycle still pulses.
        ib.test_fail     = 32'h0000_DEAD;
        ib.test_pass     = 32'h0000_0001;
        ib.test_progress = 32'd3;
        tick();
        chk("fail_result", 32'(ib.result), 32'd2);
        chk("fail_code", ib.result_code, 32'h0000_DEAD);
        chk("fail_evt", 32'(ib.progress_evt), 32'd1);
        chk("fail_pv", ib.progress_value, 32'd3);
        chk("fail_cc", ib.cycle_count, 32'd1);
        tick();

        // Reset one cycle into DRAIN.
        sim_rst = 1'b1;
        #1;
        chk_reset_vals("rst_drain");
        repeat (3) tick();
        chk("rst_drain_done", 32'(ib.done), 32'd0);
        chk("rst_drain_result", 32'(ib.result), 32'd0);
        ib.test_fail     = '0;
        ib.test_pass     = '0;
        ib.test_progress = '0;
        sim_rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("rerun_hold_dut_rst", 32'(ib.dut_rst), 32'd1);
        end
        tick();
        chk("rerun_dut_rst", 32'(ib.dut_rst), 32'd0);

        // Stall watchdog: only change at RUN edge 5, timeout 20 edges later.
        repeat (4) tick();
        ib.test_progress = 32'd1;
        tick();
        chk("stall_chg_evt", 32'(ib.progress_evt), 32'd1);
        chk("stall_chg_pv", ib.progress_value, 32'd1);
        repeat (19) tick();
        chk("stall_pre_result", 32'(ib.result), 32'd0);
        chk("stall_pre_cc", ib.cycle_count, 32'd24);
        tick();
        chk("stall_result", 32'(ib.result), 32'd3);
        chk("stall_code", ib.result_code, 32'h0000_0002);
        chk("stall_cc", ib.cycle_count, 32'd25);
        chk("stall_done0", 32'(ib.done), 32'd0);
        repeat (2) tick();
        chk("stall_done", 32'(ib.done), 32'd1);
        chk("stall_done_code", ib.result_code, 32'h0000_0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
